// File: rtl/cam_sccb_config_if.sv
// Camera SCCB configuration bus: register-table lookup, SCCB pins and status.
// master = sequencer side, slave = table/pin side.
interface cam_sccb_config_if #(
    parameter int IDX_W = 8
);
    logic             START;
    logic [IDX_W-1:0] TBL_IDX;
    logic [15:0]      TBL_DATA;
    logic             SCL;
    logic             SDA_OE;
    logic             SDA_IN;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        input  START, TBL_DATA, SDA_IN,
        output TBL_IDX, SCL, SDA_OE, BUSY, DONE, ERR
    );

    modport slave (
        output START, TBL_DATA, SDA_IN,
        input  TBL_IDX, SCL, SDA_OE, BUSY, DONE, ERR
    );
endinterface

// File: rtl/cam_sccb_config.sv
// Power-up SCCB sequencer: walks a register table and writes each entry as ID/sub-address/data.
// Optional NACK detection is enabled by defining SCCB_ACK_CHECK_EN.
module cam_sccb_config #(
    parameter int         CLK_DIV     = 125,
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         DELAY_TICKS = 500000,
    parameter int         IDX_W       = 8
) (
    input  logic               CLK,
    input  logic               RST,
    cam_sccb_config_if.master  bus
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_BYTE, S_STOP, S_GAP, S_DELAY, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;
    logic [1:0]       ph_q, ph_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [15:0]      data_q, data_d;
    logic [19:0]      dcnt_q, dcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             scl_q, scl_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tick;
    logic             nack;

`ifdef SCCB_ACK_CHECK_EN
    assign nack    = bus.SDA_IN;
    assign bus.ERR = err_q;
`else
    assign nack    = 1'b0;
    assign bus.ERR = 1'b0;
`endif

    assign tick = (qcnt_q == QW'(CLK_DIV - 1));

    function automatic logic [7:0] byte_val(input logic [1:0] sel, input logic [15:0] data);
        case (sel)
            2'd0:    return DEV_ID;
            2'd1:    return data[15:8];
            default: return data[7:0];
        endcase
    endfunction

    // SDA_OE for a bit: pull low to send 0; the ninth bit is always released for the ACK slot
    function automatic logic pull_for(input logic [7:0] b, input logic [3:0] n);
        if (n >= 4'd8) return 1'b0;
        return ~b[3'd7 - n[2:0]];
    endfunction

    always_comb begin
        state_d = state_q;
        qcnt_d  = tick ? '0 : qcnt_q + 1'b1;
        ph_d    = ph_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        data_d  = data_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        scl_d   = scl_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                qcnt_d = '0;
                scl_d  = 1'b1;
                oe_d   = 1'b0;
                if (bus.START) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                qcnt_d = '0;
                data_d = bus.TBL_DATA;
                ph_d   = '0;
                bit_d  = '0;
                byte_d = '0;
                dcnt_d = '0;
                if (bus.TBL_DATA == 16'hFFFF) begin
                    state_d = S_FIN;
                end else if (bus.TBL_DATA == 16'hFFF0) begin
                    state_d = S_DELAY;
                end else begin
                    state_d = S_START;
                    scl_d   = 1'b1;
                    oe_d    = 1'b1;
                end
            end

            S_START: begin
                if (tick) begin
                    if (ph_q == 2'd0) begin
                        ph_d  = 2'd1;
                        scl_d = 1'b0;
                    end else begin
                        state_d = S_BYTE;
                        ph_d    = '0;
                        bit_d   = '0;
                        byte_d  = '0;
                        oe_d    = pull_for(DEV_ID, 4'd0);
                    end
                end
            end

            // Each bit: q0 set SDA with SCL low, q1/q2 SCL high, q3 SCL low
            S_BYTE: begin
                if (tick) begin
                    case (ph_q)
                        2'd0: begin
                            ph_d  = 2'd1;
                            scl_d = 1'b1;
                        end
                        2'd1: ph_d = 2'd2;
                        2'd2: begin
                            ph_d  = 2'd3;
                            scl_d = 1'b0;
                            if (bit_q == 4'd8 && nack) err_d = 1'b1;
                        end
                        default: begin
                            ph_d = 2'd0;
                            if (bit_q != 4'd8) begin
                                bit_d = bit_q + 4'd1;
                                oe_d  = pull_for(byte_val(byte_q, data_q), bit_q + 4'd1);
                            end else if (err_q || byte_q == 2'd2) begin
                                state_d = S_STOP;
                                oe_d    = 1'b1;
                                scl_d   = 1'b0;
                            end else begin
                                byte_d = byte_q + 2'd1;
                                bit_d  = '0;
                                oe_d   = pull_for(byte_val(byte_q + 2'd1, data_q), 4'd0);
                            end
                        end
                    endcase
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (ph_q == 2'd0) begin
                        ph_d  = 2'd1;
                        scl_d = 1'b1;
                    end else if (ph_q == 2'd1) begin
                        ph_d = 2'd2;
                        oe_d = 1'b0;
                    end else if (err_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        ph_d    = '0;
                    end
                end
            end

            // The last table slot ends the sequence rather than wrapping back to entry 0
            S_GAP: begin
                if (tick) begin
                    if (ph_q != 2'd3) begin
                        ph_d = ph_q + 2'd1;
                    end else if (idx_q == {IDX_W{1'b1}}) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_DELAY: begin
                qcnt_d = '0;
                if (dcnt_q == 20'(DELAY_TICKS - 1)) begin
                    if (idx_q == {IDX_W{1'b1}}) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    dcnt_d = dcnt_q + 20'd1;
                end
            end

            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            dcnt_q  <= '0;
            idx_q   <= '0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.TBL_IDX = idx_q;
    assign bus.SCL     = scl_q;
    assign bus.SDA_OE  = oe_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
endmodule

// File: tb/tb_cam_sccb_config.sv
// Directed bench for cam_sccb_config: an SCCB bus model decodes the pins of two sequencer
// instances (8-bit and 2-bit table index) and each result is checked against hand-computed values.
module tb_cam_sccb_config;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cam_sccb_config_if #(.IDX_W(8)) ifa ();
    cam_sccb_config_if #(.IDX_W(2)) ifb ();

    logic [15:0] tbl_a [0:7];
    logic [15:0] tbl_b [0:3];
    logic        ack_active = 1'b0;
    logic        sda_a;

    assign ifa.TBL_DATA = (ifa.TBL_IDX < 8'd8) ? tbl_a[ifa.TBL_IDX[2:0]] : 16'hFFFF;
    assign ifb.TBL_DATA = tbl_b[ifb.TBL_IDX];
    assign sda_a        = ~ifa.SDA_OE & ~ack_active;
    assign ifa.SDA_IN   = sda_a;
    assign ifb.SDA_IN   = 1'b0;

    cam_sccb_config #(.CLK_DIV(4), .DEV_ID(8'h42), .DELAY_TICKS(100), .IDX_W(8)) dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (ifa)
    );

    cam_sccb_config #(.CLK_DIV(4), .DEV_ID(8'h42), .DELAY_TICKS(100), .IDX_W(2)) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (ifb)
    );

    // Bus model for instance a: decodes START/STOP/bytes and answers the ninth bit
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitn     = 0;
    int         byte_n   = 0;
    int         nack_sel = -1;
    logic [7:0] shreg    = '0;
    logic [7:0] rx_bytes [$];
    logic [7:0] idx_trace [$];
    logic [7:0] last_idx = '0;
    int         stop_cnt = 0;
    int         cyc      = 0;
    int         last_stop_cyc = 0;
    int         gap_cyc  = 0;

    always @(negedge clk) begin
        cyc++;
        if (prev_scl && ifa.SCL && prev_sda && !sda_a) begin
            bitn   = 0;
            byte_n = 0;
            if (stop_cnt > 0) gap_cyc = cyc - last_stop_cyc;
        end else if (prev_scl && ifa.SCL && !prev_sda && sda_a) begin
            stop_cnt++;
            last_stop_cyc = cyc;
        end else if (!prev_scl && ifa.SCL) begin
            if (bitn < 8) shreg = {shreg[6:0], sda_a};
            bitn++;
            if (bitn == 9) begin
                rx_bytes.push_back(shreg);
                bitn = 0;
                byte_n++;
            end
        end else if (prev_scl && !ifa.SCL) begin
            if (ack_active) ack_active = 1'b0;
            else if (bitn == 8 && byte_n != nack_sel) ack_active = 1'b1;
        end
        if (!ifa.BUSY) ack_active = 1'b0;
        if (ifa.TBL_IDX != last_idx) begin
            idx_trace.push_back(ifa.TBL_IDX);
            last_idx = ifa.TBL_IDX;
        end
        prev_scl = ifa.SCL;
        prev_sda = ~ifa.SDA_OE & ~ack_active;
    end

    // Instance b only needs STOP counting and a watch for the index returning to 0
    logic prev_scl_b = 1'b1;
    logic prev_sda_b = 1'b1;
    int   stop_b     = 0;
    logic left_zero_b = 1'b0;
    logic wrapped_b  = 1'b0;

    always @(negedge clk) begin
        if (prev_scl_b && ifb.SCL && !prev_sda_b && !ifb.SDA_OE) stop_b++;
        if (ifb.BUSY && ifb.TBL_IDX != 2'd0) left_zero_b = 1'b1;
        if (ifb.BUSY && left_zero_b && ifb.TBL_IDX == 2'd0) wrapped_b = 1'b1;
        prev_scl_b = ifb.SCL;
        prev_sda_b = ~ifb.SDA_OE;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit on_b);
        @(negedge clk);
        if (on_b) ifb.START = 1'b1;
        else      ifa.START = 1'b1;
        @(negedge clk);
        ifa.START = 1'b0;
        ifb.START = 1'b0;
    endtask

    task automatic wait_a_idle(input int budget, output int n);
        n = 0;
        while (ifa.BUSY && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    int base_bytes;
    int base_stops;
    int base_trace;
    int n;

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        ifa.START = 1'b0;
        ifb.START = 1'b0;
        for (int i = 0; i < 8; i++) tbl_a[i] = 16'hFFFF;
        tbl_b[0] = 16'h1111;
        tbl_b[1] = 16'h2233;
        tbl_b[2] = 16'h4455;
        tbl_b[3] = 16'h6677;
        repeat (2) @(negedge clk);

        checkOutput("rst_scl",    ifa.SCL,     1);
        checkOutput("rst_sda_oe", ifa.SDA_OE,  0);
        checkOutput("rst_busy",   ifa.BUSY,    0);
        checkOutput("rst_done",   ifa.DONE,    0);
        checkOutput("rst_err",    ifa.ERR,     0);
        checkOutput("rst_idx",    ifa.TBL_IDX, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        $display("[TB] single write 42/12/80");
        tbl_a[0]   = 16'h1280;
        tbl_a[1]   = 16'hFFFF;
        base_bytes = rx_bytes.size();
        base_stops = stop_cnt;
        applyStimulus(1'b0);
        checkOutput("w1_busy_rise", ifa.BUSY, 1);
        wait_a_idle(600, n);
        checkOutput("w1_timeout", ifa.BUSY, 0);
        checkOutput("w1_done", ifa.DONE, 1);
        checkOutput("w1_latency_window", (n >= 465 && n <= 480), 1);
        checkOutput("w1_nbytes", rx_bytes.size() - base_bytes, 3);
        checkOutput("w1_id",   rx_bytes[base_bytes],     8'h42);
        checkOutput("w1_sub",  rx_bytes[base_bytes + 1], 8'h12);
        checkOutput("w1_data", rx_bytes[base_bytes + 2], 8'h80);
        checkOutput("w1_stops", stop_cnt - base_stops, 1);
        checkOutput("w1_err", ifa.ERR, 0);

        $display("[TB] two writes around a delay entry, spurious START while busy");
        tbl_a[0]   = 16'h1180;
        tbl_a[1]   = 16'hFFF0;
        tbl_a[2]   = 16'h6B4A;
        tbl_a[3]   = 16'hFFFF;
        base_bytes = rx_bytes.size();
        base_stops = stop_cnt;
        base_trace = idx_trace.size();
        applyStimulus(1'b0);
        checkOutput("w2_done_cleared", ifa.DONE, 0);
        repeat (515) @(negedge clk);
        checkOutput("w2_idx_in_delay", ifa.TBL_IDX, 1);
        applyStimulus(1'b0);
        wait_a_idle(1500, n);
        checkOutput("w2_timeout", ifa.BUSY, 0);
        checkOutput("w2_done", ifa.DONE, 1);
        checkOutput("w2_nbytes", rx_bytes.size() - base_bytes, 6);
        checkOutput("w2_b0", rx_bytes[base_bytes],     8'h42);
        checkOutput("w2_b1", rx_bytes[base_bytes + 1], 8'h11);
        checkOutput("w2_b2", rx_bytes[base_bytes + 2], 8'h80);
        checkOutput("w2_b3", rx_bytes[base_bytes + 3], 8'h42);
        checkOutput("w2_b4", rx_bytes[base_bytes + 4], 8'h6B);
        checkOutput("w2_b5", rx_bytes[base_bytes + 5], 8'h4A);
        checkOutput("w2_stops", stop_cnt - base_stops, 2);
        checkOutput("w2_delay_gap", (gap_cyc >= 116 && gap_cyc <= 140), 1);
        checkOutput("w2_trace_len", idx_trace.size() - base_trace, 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("w2_trace%0d", i), idx_trace[base_trace + i], i);

        $display("[TB] reset in the middle of a write");
        applyStimulus(1'b0);
        repeat (100) @(negedge clk);
        checkOutput("mid_busy", ifa.BUSY, 1);
        rst_a = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_scl",  ifa.SCL,     1);
        checkOutput("mid_rst_oe",   ifa.SDA_OE,  0);
        checkOutput("mid_rst_busy", ifa.BUSY,    0);
        checkOutput("mid_rst_done", ifa.DONE,    0);
        checkOutput("mid_rst_idx",  ifa.TBL_IDX, 0);
        ifa.START = 1'b1;
        @(negedge clk);
        checkOutput("start_with_rst", ifa.BUSY, 0);
        ifa.START = 1'b0;
        rst_a     = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_idle", ifa.BUSY, 0);

`ifdef SCCB_ACK_CHECK_EN
        $display("[TB] NACK on the sub-address byte");
        tbl_a[0]   = 16'h1280;
        tbl_a[1]   = 16'hFFFF;
        nack_sel   = 1;
        base_bytes = rx_bytes.size();
        base_stops = stop_cnt;
        applyStimulus(1'b0);
        wait_a_idle(600, n);
        nack_sel = -1;
        checkOutput("nack_timeout", ifa.BUSY, 0);
        checkOutput("nack_err",  ifa.ERR,  1);
        checkOutput("nack_done", ifa.DONE, 0);
        checkOutput("nack_nbytes", rx_bytes.size() - base_bytes, 2);
        checkOutput("nack_stops", stop_cnt - base_stops, 1);
`else
        checkOutput("err_tied_low", ifa.ERR, 0);
`endif

        $display("[TB] 2-bit index, table without end marker");
        applyStimulus(1'b1);
        checkOutput("b_busy_rise", ifb.BUSY, 1);
        n = 0;
        while (!ifb.DONE && n < 2500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b_done", ifb.DONE, 1);
        checkOutput("b_busy", ifb.BUSY, 0);
        checkOutput("b_writes", stop_b, 4);
        checkOutput("b_idx_last", ifb.TBL_IDX, 3);
        checkOutput("b_no_wrap", wrapped_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
